// File: rtl/frame_bcd_counter_if.sv
// Load channel for frame_bcd_counter: valid/ready handshake carrying four
// BCD digits. The master drives the request; the counter (slave) answers
// with load_ready.
interface frame_bcd_counter_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (output load_valid, output load_data, input  load_ready);
  modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/frame_bcd_counter.sv
// Frame-synchronous four-digit BCD up/down counter.
// Detects the vsync falling edge, divides frames by FRAMES_PER_STEP and
// steps the displayed value only on frame starts so the display never
// tears. Loads are double-buffered: captured into a hold register and
// applied on the next frame start.

// One BCD digit of the counter: next value with ripple carry/borrow, plus
// the clamp used when capturing load data into the hold register.
module frame_bcd_lane #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] cur,
  input  logic             up,
  input  logic             cin,
  input  logic [VEC_W-1:0] raw,
  output logic [VEC_W-1:0] nxt,
  output logic             cout,
  output logic [VEC_W-1:0] clamped
);
  localparam logic [VEC_W-1:0] D_MAX  = VEC_W'(9);
  localparam logic [VEC_W-1:0] D_ZERO = '0;
  localparam logic [VEC_W-1:0] D_ONE  = VEC_W'(1);

  // Ripple step: only moves when the lower digit carried/borrowed into it.
  always_comb begin
    nxt  = cur;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (cur >= D_MAX) begin
          nxt  = D_ZERO;
          cout = 1'b1;
        end else begin
          nxt = cur + D_ONE;
        end
      end else begin
        if (cur == D_ZERO) begin
          nxt  = D_MAX;
          cout = 1'b1;
        end else begin
          nxt = cur - D_ONE;
        end
      end
    end
  end

  // Non-BCD nibbles are saturated to 9 so the display only ever sees digits.
  assign clamped = (raw > D_MAX) ? D_MAX : raw;
endmodule

module frame_bcd_counter #(
  parameter int FRAMES_PER_STEP = 60   // legal 1..1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                en,
  input  logic                up,
  frame_bcd_counter_if.slave  load,
  output logic [15:0]         num_string,
  output logic                frame_tick,
  output logic                wrap
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;
  localparam logic [9:0] DIV_LAST = 10'(FRAMES_PER_STEP - 1);

  typedef enum logic {IDLE, PEND} state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] val;
    logic                            wrap;
  } step_t;

  state_t      state;
  logic        vsync_q;
  logic [9:0]  divider;
  logic [15:0] hold;
  logic        load_ready_q;
  logic        fs;
  logic        xfer;

  logic [NUM_LANES-1:0][VEC_W-1:0] cur_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] raw_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] nxt_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] clamp_d;
  logic [NUM_LANES:0]              carry;
  step_t                           step;

  assign fs       = vsync_q & ~vsync;
  assign xfer     = load.load_valid & load_ready_q;
  assign cur_d    = num_string;
  assign raw_d    = load.load_data;
  assign carry[0] = 1'b1;

  // Digit chain: least significant lane always receives the step.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    frame_bcd_lane #(.VEC_W(VEC_W)) u_lane (
      .cur     (cur_d[i]),
      .up      (up),
      .cin     (carry[i]),
      .raw     (raw_d[i]),
      .nxt     (nxt_d[i]),
      .cout    (carry[i+1]),
      .clamped (clamp_d[i])
    );
  end

  assign step.val  = nxt_d;
  assign step.wrap = carry[NUM_LANES];

  assign load.load_ready = load_ready_q;

  // Frame-start detect, load FSM, frame divider and display update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vsync_q      <= 1'b1;
      divider      <= '0;
      hold         <= '0;
      load_ready_q <= 1'b1;
      num_string   <= '0;
      frame_tick   <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= fs;
      wrap       <= 1'b0;
      case (state)
        IDLE: begin
          // A load seen on a frame-start edge still waits a full frame.
          if (xfer) begin
            hold         <= clamp_d;
            load_ready_q <= 1'b0;
            state        <= PEND;
          end
          if (fs && en) begin
            if (divider == DIV_LAST) begin
              divider    <= '0;
              num_string <= step.val;
              wrap       <= step.wrap;
            end else begin
              divider <= divider + 10'd1;
            end
          end
        end
        PEND: begin
          // Applied regardless of en; this frame takes no count step.
          if (fs) begin
            num_string   <= hold;
            divider      <= '0;
            load_ready_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
